// File: rtl/shift_code_encoder.sv
// shift_code_encoder
//   Sequential normalizer for the divider's barrel-shift path. It takes an
//   8-bit operand and returns the left-shift count (shift code) that brings
//   its leading one to the MSB, together with the normalized value. Applying
//   `sh` to the original operand through the barrel shifter reproduces `norm`.
//   Only one operand is in flight at a time. The leading one is found by
//   shifting left once per cycle.
//
// Ports
//   clk        in   clock; all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand `a` valid
//   in_ready   out  block can accept an operand (IDLE and not in reset)
//   a          in   [WIDTH-1:0] operand
//   out_valid  out  result valid (registered, high exactly in DONE)
//   out_ready  in   consumer accepts result
//   sh         out  [SHW-1:0] shift code: 0..7, or 8 for a zero operand
//   norm       out  [WIDTH-1:0] (a << sh) mod 2^WIDTH
//   zero       out  operand was zero
//
// Parameters
//   WIDTH  operand width; 8 is the only supported value
//   SHW    shift-code width; must hold 0..WIDTH

module shift_code_encoder #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SHW-1:0]   sh,
  output logic [WIDTH-1:0] norm,
  output logic             zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic [SHW-1:0]   r_sh;
  logic [WIDTH-1:0] r_norm;
  logic             r_zero;
  logic             r_out_valid;

  logic             w_accept;

  // in_ready is decoded from the registered state. It is also gated by rst,
  // so nothing is offered while the block is being reset.
  assign in_ready = (r_state == S_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_sh        <= '0;
      r_norm      <= '0;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_work <= a;
            r_cnt  <= '0;
            if (a == '0) begin
              // A zero operand has no leading one. It skips the scan and
              // reports the out-of-range code WIDTH.
              r_state     <= S_DONE;
              r_sh        <= SHW'(WIDTH);
              r_norm      <= '0;
              r_zero      <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end

        S_SCAN: begin
          if (r_work[WIDTH-1]) begin
            r_state     <= S_DONE;
            r_sh        <= r_cnt;
            r_norm      <= r_work;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            // A nonzero operand reaches the MSB within WIDTH-1 shifts, so
            // r_cnt stays at or below 7 here.
            r_work <= r_work << 1;
            r_cnt  <= r_cnt + SHW'(1);
          end
        end

        S_DONE: begin
          // Results stay in place after the handshake. They change only on
          // the next completion or on reset.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign sh        = r_sh;
  assign norm      = r_norm;
  assign zero      = r_zero;

endmodule

// File: doc/shift_code_encoder.md
# shift_code_encoder

Sequential normalizer that computes the 4-bit shift code for an 8-bit operand: the left-shift count that brings its leading one to the MSB, plus the normalized value. It is the encoding side of the divider's barrel-shift path. Its `sh` output is the code the barrel shifter consumes, so applying `sh` to the original operand reproduces `norm`. Operands arrive and results leave through valid/ready handshakes, one operand in flight at a time.

## Interface
- `WIDTH`, 8, operand width; `WIDTH` = 8 is the only supported value.
- `SHW`, 4, shift-code width; must hold values 0..`WIDTH`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand `a` is valid.
- `in_ready`  out  1  block can accept an operand.
- `a`  in  `WIDTH`  operand.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `sh`  out  `SHW`  shift code: left-shift count 0..7, or 8 for a zero operand.
- `norm`  out  `WIDTH`  normalized operand, equal to (`a` << `sh`) mod 2^8.
- `zero`  out  1  operand was zero.

## Operation
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - Accept when `in_valid`&&`in_ready` at an edge.
    - Capture `a` into the work register; shift counter `cnt` = 0.
    - If `a`==0, go to DONE and register `sh`=8, `norm`=0, `zero`=1.
    - Otherwise go to SCAN.
  - SCAN, one step per cycle:
    - If work[7]==1, go to DONE and register `sh`=`cnt`, `norm`=work, `zero`=0.
    - Otherwise work <= work<<1 (zero fill) and `cnt` <= `cnt`+1.
  - DONE:
    - `out_valid`=1.
    - `sh`, `norm` and `zero` are held stable until `out_valid`&&`out_ready` at an edge, then go to IDLE.
- `in_ready` = (state==IDLE) && !`rst`. It is combinational from the registered state. `in_valid` outside IDLE is ignored, and `a` is not sampled.
- `out_valid` is registered, and is high exactly when state==DONE.
- `cnt` never exceeds 7 in SCAN, because a nonzero operand always reaches work[7] within 7 shifts. `cnt` is 4 bits wide; code 8 arises only on the zero path.
- Code range: results use only codes 0..8, i.e. pure left shifts. Codes 9..15 are never produced.
- Invariants:
  - For `a`!=0: `norm`[7]==1, and `sh` equals the leading-zero count of `a`.
  - For `a`==0: `sh`=8, `norm`=0, `zero`=1.

## Timing
- Reset (`rst` high at an edge) gives: state IDLE, `out_valid`=0, `sh`=0, `norm`=0, `zero`=0, `cnt`=0, work=0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after release.
- Reset takes priority over every handshake. Asserting it in SCAN or DONE aborts the operation, and no result is presented.
- Latency is measured from accept edge E0 to the edge after which `out_valid` is high:
  - Zero operand: 1 cycle.
  - Nonzero operand with k leading zeros: k+1 cycles (SCAN occupies E1..Ek for the shifts; DONE is entered at E(k+1)). Minimum 1 (`a`[7]=1), maximum 8 (`a`=8'h01).
- Output handshake completes on the first edge with `out_ready`=1 while `out_valid`=1. This includes the first DONE cycle.
- Next cycle: `out_valid`=0 and `in_ready`=1. No accept occurs on the handshake edge itself.
- Throughput: one result per k+3 cycles at best (accept, k+1 compute, handshake, one IDLE cycle overlapped with the next accept).
- `out_ready` has no effect outside DONE. Backpressure in DONE holds all outputs for any duration.

## Test plan
- `a`=8'h80, `out_ready`=1: `out_valid` high 1 cycle after accept; `sh`=0, `norm`=8'h80, `zero`=0; `in_ready` back to 1 the cycle after handshake.
- `a`=8'h01: `out_valid` rises 8 cycles after accept; `sh`=7, `norm`=8'h80, `zero`=0.
- `a`=8'h00: `out_valid` 1 cycle after accept; `sh`=8, `norm`=8'h00, `zero`=1.
- `a`=8'h13 with `out_ready` held low 5 cycles in DONE, while `in_valid` stays high with `a`=8'hFF:
  - `sh`=3, `norm`=8'h98 stable throughout.
  - `in_ready`=0 throughout; 8'hFF is accepted only after the handshake, then yields `sh`=0.
- `a`=8'h02, `rst` pulsed for one cycle during SCAN: `out_valid` stays 0, all outputs return to 0, and `in_ready`=1 after release. A following `a`=8'h40 yields `sh`=1, `norm`=8'h80.
- Sweep `a`=0..255 with `out_ready`=1 and random `in_valid` gaps:
  - Every result satisfies `norm`==(`a`<<`sh`) mod 256.
  - `norm`[7]==1 for `a`!=0.
  - `sh` equals the reference leading-zero count.
  - Latency matches k+1.
